// File: rtl/health_calc_sched.sv
// ---------------------------------------------------------------------------
// health_calc_sched
//
// Purpose:
//   Takes BMI/BMR jobs from two requesters and sends them to an external calc
//   core as a fixed instruction sequence. It returns one response per job.
//   Arbitration is round-robin. Jobs with a zero height or a zero weight are
//   rejected straight away and issue no instructions.
//
// Handshake rule (every valid/ready pair in this block):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   - A requester holds reqN_valid and its payload until it sees reqN_ready.
//   - reqN_ready is combinational from the state and the valids. It is only
//     ever high in IDLE.
//   - rsp_valid stays high, and rsp_* stays stable, until the consumer
//     completes the handshake with rsp_ready.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   reqN_valid/ready           job request handshake (N = 0,1)
//   reqN_height/weight/age/male job payload (cm, kg, years, 1 = male)
//   instr_o                    instruction to the calc core
//   result_i                   calc core result bus (low 16 bits used)
//   rsp_valid/ready            response handshake
//   rsp_id/bmi/bmr/err         response payload
//   busy                       high whenever the FSM is not in IDLE
//   o_dbg_state                current FSM state, for observation
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module health_calc_sched #(
  parameter int unsigned CALC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [11:0] req0_height,
  input  logic [11:0] req0_weight,
  input  logic [5:0]  req0_age,
  input  logic        req0_male,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [11:0] req1_height,
  input  logic [11:0] req1_weight,
  input  logic [5:0]  req1_age,
  input  logic        req1_male,
  output logic [31:0] instr_o,
  input  logic [31:0] result_i,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_bmi,
  output logic [15:0] rsp_bmr,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_H    = 3'd1,
    SET_W    = 3'd2,
    CALC_BMI = 3'd3,
    CALC_BMR = 3'd4,
    RESP     = 3'd5
  } state_t;

  // Counter value on the final cycle of a CALC state.
  localparam logic [3:0] LAST_CNT = 4'(CALC_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [11:0] r_height;
  logic [11:0] r_weight;
  logic [5:0]  r_age;
  logic        r_male;
  logic        r_id;
  logic [15:0] r_bmi;
  logic [15:0] r_bmr;
  logic        r_err;
  // This holds the requester that was granted last. Its reset value is 1, so
  // requester 0 wins the first tie.
  logic        r_last;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [11:0] w_sel_height;
  logic [11:0] w_sel_weight;
  logic [5:0]  w_sel_age;
  logic        w_sel_male;
  logic        w_sel_zero;
  logic        w_calc_last;
  logic        w_unused;

  // Only the low half of the result bus carries data.
  assign w_unused = ^result_i[31:16];

  // Arbitration. When both requesters are valid, the one not granted last wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == IDLE) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last;
        w_grant1 = ~r_last;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign w_accept     = w_grant0 | w_grant1;
  assign w_sel_height = w_grant1 ? req1_height : req0_height;
  assign w_sel_weight = w_grant1 ? req1_weight : req0_weight;
  assign w_sel_age    = w_grant1 ? req1_age    : req0_age;
  assign w_sel_male   = w_grant1 ? req1_male   : req0_male;
  assign w_sel_zero   = (w_sel_height == 12'd0) || (w_sel_weight == 12'd0);
  assign w_calc_last  = (r_cnt == LAST_CNT);

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = w_sel_zero ? RESP : SET_H;
      SET_H:    w_next = SET_W;
      SET_W:    w_next = CALC_BMI;
      CALC_BMI: if (w_calc_last) w_next = CALC_BMR;
      CALC_BMR: if (w_calc_last) w_next = RESP;
      RESP:     if (rsp_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Instruction bus. It is driven from state only, so it is zero in IDLE and
  // in reset.
  always_comb begin
    instr_o = 32'h0;
    case (r_state)
      SET_H:    instr_o = {r_height, 5'd0, 3'b000, 5'd0, 7'b0001011};
      SET_W:    instr_o = {r_weight, 5'd0, 3'b001, 5'd0, 7'b0001011};
      CALC_BMI: instr_o = {7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0001101};
      CALC_BMR: instr_o = {r_male, r_age, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0001110};
      default:  instr_o = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      // The counter restarts on every state change.
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_height <= 12'd0;
      r_weight <= 12'd0;
      r_age    <= 6'd0;
      r_male   <= 1'b0;
      r_id     <= 1'b0;
      r_bmi    <= 16'd0;
      r_bmr    <= 16'd0;
      r_err    <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      if (w_accept) begin
        r_height <= w_sel_height;
        r_weight <= w_sel_weight;
        r_age    <= w_sel_age;
        r_male   <= w_sel_male;
        r_id     <= w_grant1;
        r_last   <= w_grant1;
        r_bmi    <= 16'd0;
        r_bmr    <= 16'd0;
        r_err    <= w_sel_zero;
      end
      if (r_state == CALC_BMI && w_calc_last) r_bmi <= result_i[15:0];
      if (r_state == CALC_BMR && w_calc_last) r_bmr <= result_i[15:0];
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_id      = r_id;
  assign rsp_bmi     = r_bmi;
  assign rsp_bmr     = r_bmr;
  assign rsp_err     = r_err;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule
